// File: rtl/mpc_div_36s_15s_21_seq.sv
// Sequential signed restoring divider, 36s / 15s -> saturated 21s quotient.
// Build option: MPC_DIV_ROUND_EN rounds the quotient half away from zero.
module mpc_div_36s_15s_21_seq #(
  parameter int DIVIDEND_W = 36,
  parameter int DIVISOR_W  = 15,
  parameter int QUOT_W     = 21
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic                         start,
  input  logic signed [DIVIDEND_W-1:0] a,
  input  logic signed [DIVISOR_W-1:0]  b,
  output logic                         ready,
  output logic                         done,
  output logic signed [QUOT_W-1:0]     q,
  output logic signed [DIVISOR_W-1:0]  r,
  output logic                         ovf,
  output logic                         dz
);

  localparam int AW = DIVIDEND_W;
  localparam int DW = DIVISOR_W;
  localparam int QW = QUOT_W;
  localparam int CW = $clog2(AW);

  localparam logic [AW:0] QPOS = (AW+1)'((64'd1 << (QW-1)) - 64'd1);
  localparam logic [AW:0] QNEGM = (AW+1)'(64'd1 << (QW-1));
  localparam logic [CW-1:0] LAST = CW'(AW-1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sa_q, sa_d;
  logic sb_q, sb_d;
  logic [AW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] bmag_q, bmag_d;
  logic [DW-1:0] rem_q, rem_d;
  logic done_q, done_d;
  logic [QW-1:0] q_q, q_d;
  logic [DW-1:0] r_q, r_d;
  logic ovf_q, ovf_d;
  logic dz_q, dz_d;

  logic [DW:0] trial;
  logic ge;
  logic neg;
  logic rnd;
  logic [AW:0] qmag;
  logic sat;
  logic [QW-1:0] qval;
  logic [DW-1:0] rval;

  // Datapath helpers: one restoring step and the sign/saturation fix-up.
  always_comb begin
    trial = {rem_q, dvd_q[AW-1]};
    ge    = trial >= {1'b0, bmag_q};
    neg   = sa_q ^ sb_q;
`ifdef MPC_DIV_ROUND_EN
    rnd   = {rem_q, 1'b0} >= {1'b0, bmag_q};
`else
    rnd   = 1'b0;
`endif
    qmag  = {1'b0, dvd_q} + (AW+1)'(rnd);
    sat   = neg ? (qmag > QNEGM) : (qmag > QPOS);
    if (sat)
      qval = neg ? {1'b1, {(QW-1){1'b0}}}
                 : {1'b0, {(QW-1){1'b1}}};
    else
      qval = neg ? -qmag[QW-1:0] : qmag[QW-1:0];
    rval  = sa_q ? -rem_q : rem_q;
  end

  // Next-state and output logic for the IDLE/CALC/FIX sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dvd_d   = dvd_q;
    bmag_d  = bmag_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    q_d     = q_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          sa_d    = a[AW-1];
          sb_d    = b[DW-1];
          dvd_d   = a[AW-1] ? AW'(-a) : AW'(a);
          bmag_d  = b[DW-1] ? DW'(-b) : DW'(b);
          rem_d   = '0;
        end
      end
      CALC: begin
        rem_d = ge ? DW'(trial - {1'b0, bmag_q})
                   : trial[DW-1:0];
        dvd_d = {dvd_q[AW-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (bmag_q == '0) begin
          q_d   = sa_q ? {1'b1, {(QW-1){1'b0}}}
                       : {1'b0, {(QW-1){1'b1}}};
          r_d   = '0;
          ovf_d = 1'b0;
          dz_d  = 1'b1;
        end else begin
          q_d   = qval;
          r_d   = rval;
          ovf_d = sat;
          dz_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register: sync reset wins, otherwise advance only on ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dvd_q   <= '0;
      bmag_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dvd_q   <= dvd_d;
      bmag_q  <= bmag_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign q     = q_q;
  assign r     = r_q;
  assign ovf   = ovf_q;
  assign dz    = dz_q;

endmodule

// File: tb/tb_mpc_div_36s_15s_21_seq.sv
// Directed bench for the 36s/15s sequential divider.
// Expected values are hand-computed quotients/remainders.
module tb_mpc_div_36s_15s_21_seq;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  logic start;
  logic signed [35:0] a;
  logic signed [14:0] b;
  logic ready;
  logic done;
  logic signed [20:0] q;
  logic signed [14:0] r;
  logic ovf;
  logic dz;

  int checks = 0;
  int errors = 0;

  mpc_div_36s_15s_21_seq dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start),
    .a(a), .b(b), .ready(ready), .done(done),
    .q(q), .r(r), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_div(input string tag,
                        input logic signed [35:0] av,
                        input logic signed [14:0] bv,
                        input logic signed [20:0] eq,
                        input logic signed [14:0] er,
                        input logic eo,
                        input logic ez);
    int n;
    bit busy_ok;
    n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_rdy"}, 64'(ready), 64'd1);
    ce = 1'b1;
    a = av;
    b = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 100) begin
      if (ready) busy_ok = 1'b0;
      step();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd37);
    chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    chk({tag, "_q"}, 64'(q), 64'(eq));
    chk({tag, "_r"}, 64'(r), 64'(er));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    chk({tag, "_dz"}, 64'(dz), 64'(ez));
  endtask

  initial begin
    int n;
    int cen;
    bit seen;
    bit held;
    rst = 1'b1;
    ce = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_r", 64'(r), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    rst = 1'b0;
    ce = 1'b1;
    step();

    do_div("p100_7", 36'sd100, 15'sd7, 21'sd14, 15'sd2, 1'b0, 1'b0);
    do_div("n100_7", -36'sd100, 15'sd7, -21'sd14, -15'sd2, 1'b0, 1'b0);
`ifdef MPC_DIV_ROUND_EN
    do_div("n100_8", -36'sd100, 15'sd8, -21'sd13, -15'sd4, 1'b0, 1'b0);
`else
    do_div("n100_8", -36'sd100, 15'sd8, -21'sd12, -15'sd4, 1'b0, 1'b0);
`endif
    do_div("satpos", 36'sd34359738367, 15'sd1,
           21'sd1048575, 15'sd0, 1'b1, 1'b0);
    do_div("satmm", -36'sd34359738368, -15'sd1,
           21'sd1048575, 15'sd0, 1'b1, 1'b0);
    do_div("satneg", -36'sd34359738368, 15'sd1,
           -21'sd1048576, 15'sd0, 1'b1, 1'b0);
    do_div("bmin", 36'sd100000, -15'sd16384,
           -21'sd6, 15'sd1696, 1'b0, 1'b0);
    do_div("bmin2", -36'sd100000, -15'sd16384,
           21'sd6, -15'sd1696, 1'b0, 1'b0);
    do_div("dzneg", -36'sd5, 15'sd0,
           -21'sd1048576, 15'sd0, 1'b0, 1'b1);
    do_div("dzpos", 36'sd5, 15'sd0,
           21'sd1048575, 15'sd0, 1'b0, 1'b1);

    step();
    ce = 1'b0;
    a = 36'sd9;
    b = 15'sd2;
    start = 1'b1;
    step();
    step();
    step();
    chk("ce0_start_ready", 64'(ready), 64'd1);
    start = 1'b0;
    ce = 1'b1;
    step();
    chk("ce0_start_ready2", 64'(ready), 64'd1);
    chk("ce0_start_q", 64'(q), 64'd1048575);

    a = 36'sd1000;
    b = -15'sd3;
    start = 1'b1;
    ce = 1'b1;
    step();
    start = 1'b0;
    chk("cet_accept", 64'(ready), 64'd0);
    cen = 0;
    n = 0;
    while (!done && n < 200) begin
      ce = ~ce;
      if (cen >= 10 && cen <= 11) begin
        start = 1'b1;
        a = 36'sd7;
        b = 15'sd1;
      end else begin
        start = 1'b0;
      end
      step();
      if (ce) cen++;
      n++;
    end
    start = 1'b0;
    chk("cet_lat", 64'(cen), 64'd37);
    chk("cet_q", 64'(q), -64'sd333);
    chk("cet_r", 64'(r), 64'sd1);
    chk("cet_ovf", 64'(ovf), 64'd0);
    ce = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done !== 1'b1) held = 1'b0;
    end
    chk("done_hold", 64'(held), 64'd1);
    ce = 1'b1;
    step();
    chk("done_clear", 64'(done), 64'd0);
    chk("after_busy_ready", 64'(ready), 64'd1);

    a = 36'sd12345;
    b = 15'sd11;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("mid_busy", 64'(ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ready", 64'(ready), 64'd1);
    chk("mid_rst_q", 64'(q), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    chk("mid_rst_nodone", 64'(seen), 64'd0);
    do_div("post_rst", 36'sd100, 15'sd7, 21'sd14, 15'sd2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
